// File: rtl/mix_columns_iter.sv
// Column-serial AES MixColumns (InvMixColumns with MIX_COLUMNS_INV_EN): one column per cycle, 4-cycle latency.
// Result held in DONE until out_ready; in_ready/out_valid decode registered state only.
module mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_data,
  input  logic         in_valid,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [31:0]  col_cur, col_res;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv_q, inv_d;
`endif

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // Returns {14x, 13x, 11x, 9x} from the chained xtime products.
  function automatic logic [31:0] inv_mults(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x4 ^ x, x8 ^ x2 ^ x, x8 ^ x};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] e0, d0, b0, n0, e1, d1, b1, n1, e2, d2, b2, n2, e3, d3, b3, n3;
    {e0, d0, b0, n0} = inv_mults(c[31:24]);
    {e1, d1, b1, n1} = inv_mults(c[23:16]);
    {e2, d2, b2, n2} = inv_mults(c[15:8]);
    {e3, d3, b3, n3} = inv_mults(c[7:0]);
    return {e0 ^ b1 ^ d2 ^ n3,
            n0 ^ e1 ^ b2 ^ d3,
            d0 ^ n1 ^ e2 ^ b3,
            b0 ^ d1 ^ n2 ^ e3};
  endfunction
`endif

  always_comb begin
    case (col_q)
      2'd0:    col_cur = data_q[127:96];
      2'd1:    col_cur = data_q[95:64];
      2'd2:    col_cur = data_q[63:32];
      default: col_cur = data_q[31:0];
    endcase
`ifdef MIX_COLUMNS_INV_EN
    col_res = inv_q ? mix_inv(col_cur) : mix_fwd(col_cur);
`else
    col_res = mix_fwd(col_cur);
`endif
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
`ifdef MIX_COLUMNS_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          col_d   = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
          inv_d   = inv;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0:    data_d[127:96] = col_res;
          2'd1:    data_d[95:64]  = col_res;
          2'd2:    data_d[63:32]  = col_res;
          default: data_d[31:0]   = col_res;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'd0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
`ifdef MIX_COLUMNS_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule
